// File: rtl/sdc_pkg.sv
// Shared definitions for the SD DAT-bus write path: status codes, CRC16 polynomial, FSM states.
package sdc_pkg;

  localparam logic [2:0] STS_OK        = 3'd0;
  localparam logic [2:0] STS_CRC_ERR   = 3'd1;
  localparam logic [2:0] STS_WRITE_ERR = 3'd2;
  localparam logic [2:0] STS_NO_TOKEN  = 3'd3;
  localparam logic [2:0] STS_BUSY_TO   = 3'd4;
  localparam logic [2:0] STS_UNDERRUN  = 3'd5;
  localparam logic [2:0] STS_BAD_TOKEN = 3'd6;

  localparam logic [15:0] CRC16_POLY = 16'h1021;

  typedef enum logic [3:0] {
    DAT_IDLE,
    DAT_PRELOAD,
    DAT_START,
    DAT_DATA,
    DAT_CRC,
    DAT_END,
    DAT_TURN,
    DAT_TOKEN,
    DAT_TOKBITS,
    DAT_BUSY
  } dat_state_t;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    crc16_step = {crc[14:0], 1'b0} ^ (((crc[15] ^ bit_in) == 1'b1) ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/sdc_crc16_x4.sv
// Four independent serial CRC16-CCITT generators, one per DAT line.
module sdc_crc16_x4
  import sdc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [3:0]  bits,
  output logic [15:0] crc0,
  output logic [15:0] crc1,
  output logic [15:0] crc2,
  output logic [15:0] crc3
);

  logic [15:0] r_crc [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) r_crc[i] <= '0;
    end else if (clr) begin
      for (int unsigned i = 0; i < 4; i++) r_crc[i] <= '0;
    end else if (en) begin
      for (int unsigned i = 0; i < 4; i++) r_crc[i] <= crc16_step(r_crc[i], bits[i]);
    end
  end

  assign crc0 = r_crc[0];
  assign crc1 = r_crc[1];
  assign crc2 = r_crc[2];
  assign crc3 = r_crc[3];

endmodule

// File: rtl/sdc_dat_tx.sv
// 4-bit SD DAT-bus block transmitter: start bit, payload nibbles, per-line CRC16, end bit,
// then CRC-status token capture and DAT0 busy wait with one status report per block.
module sdc_dat_tx
  import sdc_pkg::*;
#(
  parameter int unsigned BLOCK_BYTES  = 512,
  parameter int unsigned TOKEN_WINDOW = 16,
  parameter int unsigned BUSY_TO_BITS = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [BUSY_TO_BITS-1:0] busy_timeout,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    clk_out_stb,
  input  logic                    clk_sample_stb,
  input  logic [3:0]              dat_in,
  output logic [3:0]              dat_out,
  output logic                    dat_en,
  output logic                    active,
  output logic                    done,
  output logic [2:0]              status
);

  localparam int unsigned NIBBLES = 2 * BLOCK_BYTES;
  localparam int unsigned NW = $clog2(NIBBLES);
  localparam int unsigned FW = $clog2(BLOCK_BYTES + 1);
  localparam int unsigned WW = $clog2(TOKEN_WINDOW + 1);
  localparam int unsigned BW = BUSY_TO_BITS + 1;

  dat_state_t              r_state, w_state;
  logic [3:0]              r_dat_out, w_dat_out;
  logic                    r_dat_en, w_dat_en;
  logic                    r_done, w_done;
  logic [2:0]              r_status, w_status;
  logic [7:0]              r_hold, w_hold;
  logic                    r_hold_full, w_hold_full;
  logic [3:0]              r_cur, w_cur;
  logic [FW-1:0]           r_fetched, w_fetched;
  logic [NW-1:0]           r_nib, w_nib;
  logic [3:0]              r_bit, w_bit;
  logic [WW-1:0]           r_win, w_win;
  logic [2:0]              r_tok, w_tok;
  logic [1:0]              r_tokcnt, w_tokcnt;
  logic [BUSY_TO_BITS-1:0] r_busy_to, w_busy_to;
  logic [BW-1:0]           r_busy_cnt, w_busy_cnt;

  logic        w_out, w_smp, w_accept, w_finish;
  logic        w_crc_clr, w_crc_en;
  logic [3:0]  w_crc_bits;
  logic [15:0] w_crc0, w_crc1, w_crc2, w_crc3;
  logic [BW-1:0] w_busy_inc;
  logic        w_unused_dat;

  sdc_crc16_x4 u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_crc_clr),
    .en    (w_crc_en),
    .bits  (w_crc_bits),
    .crc0  (w_crc0),
    .crc1  (w_crc1),
    .crc2  (w_crc2),
    .crc3  (w_crc3)
  );

  // Output strobe wins a collision; the sample is simply dropped.
  assign w_out        = clk_out_stb;
  assign w_smp        = clk_sample_stb & ~clk_out_stb;
  assign in_ready     = (r_state != DAT_IDLE) & ~r_hold_full & (r_fetched < FW'(BLOCK_BYTES));
  assign w_accept     = in_valid & in_ready;
  assign w_busy_inc   = r_busy_cnt + BW'(1);
  assign w_unused_dat = &{1'b0, dat_in[3:1]};

  always_comb begin
    w_state    = r_state;
    w_dat_out  = r_dat_out;
    w_dat_en   = r_dat_en;
    w_done     = 1'b0;
    w_status   = r_status;
    w_hold     = r_hold;
    w_hold_full = r_hold_full;
    w_cur      = r_cur;
    w_fetched  = r_fetched;
    w_nib      = r_nib;
    w_bit      = r_bit;
    w_win      = r_win;
    w_tok      = r_tok;
    w_tokcnt   = r_tokcnt;
    w_busy_to  = r_busy_to;
    w_busy_cnt = r_busy_cnt;
    w_crc_clr  = 1'b0;
    w_crc_en   = 1'b0;
    w_crc_bits = '0;
    w_finish   = 1'b0;

    if (w_accept) begin
      w_hold      = in_data;
      w_hold_full = 1'b1;
      w_fetched   = r_fetched + FW'(1);
    end

    case (r_state)
      DAT_IDLE: begin
        if (start && !r_done) begin
          w_state     = DAT_PRELOAD;
          w_crc_clr   = 1'b1;
          w_fetched   = '0;
          w_hold_full = 1'b0;
          w_nib       = '0;
          w_bit       = 4'd15;
          w_win       = '0;
          w_tokcnt    = '0;
          w_busy_to   = busy_timeout;
          w_busy_cnt  = '0;
        end
      end
      DAT_PRELOAD: if (r_hold_full) w_state = DAT_START;
      DAT_START: begin
        if (w_out) begin
          w_dat_en  = 1'b1;
          w_dat_out = '0;
          w_state   = DAT_DATA;
        end
      end
      DAT_DATA: begin
        if (w_out) begin
          if (!r_nib[0]) begin
            if (!r_hold_full) begin
              w_status = STS_UNDERRUN;
              w_finish = 1'b1;
            end else begin
              w_dat_out   = r_hold[7:4];
              w_cur       = r_hold[3:0];
              w_hold_full = 1'b0;
              w_crc_en    = 1'b1;
              w_crc_bits  = r_hold[7:4];
              w_nib       = r_nib + NW'(1);
            end
          end else begin
            w_dat_out  = r_cur;
            w_crc_en   = 1'b1;
            w_crc_bits = r_cur;
            if (r_nib == NW'(NIBBLES - 1)) begin
              w_state = DAT_CRC;
              w_bit   = 4'd15;
            end else begin
              w_nib = r_nib + NW'(1);
            end
          end
        end
      end
      DAT_CRC: begin
        if (w_out) begin
          w_dat_out = {w_crc3[r_bit], w_crc2[r_bit], w_crc1[r_bit], w_crc0[r_bit]};
          if (r_bit == 4'd0) w_state = DAT_END;
          else               w_bit   = r_bit - 4'd1;
        end
      end
      DAT_END: begin
        if (w_out) begin
          w_dat_out = '1;
          w_state   = DAT_TURN;
        end
      end
      DAT_TURN: begin
        if (w_out) begin
          w_dat_en  = 1'b0;
          w_dat_out = '1;
          w_win     = '0;
          w_state   = DAT_TOKEN;
        end
      end
      DAT_TOKEN: begin
        if (w_smp) begin
          if (!dat_in[0]) begin
            w_state  = DAT_TOKBITS;
            w_tokcnt = '0;
          end else if (r_win == WW'(TOKEN_WINDOW - 1)) begin
            w_status = STS_NO_TOKEN;
            w_finish = 1'b1;
          end else begin
            w_win = r_win + WW'(1);
          end
        end
      end
      DAT_TOKBITS: begin
        if (w_smp) begin
          if (r_tokcnt == 2'd3) begin
            if (!dat_in[0]) begin
              w_status = STS_BAD_TOKEN;
              w_finish = 1'b1;
            end else begin
              case (r_tok)
                3'b010: begin
                  w_state    = DAT_BUSY;
                  w_busy_cnt = '0;
                end
                3'b101:  begin w_status = STS_CRC_ERR;   w_finish = 1'b1; end
                3'b110:  begin w_status = STS_WRITE_ERR; w_finish = 1'b1; end
                default: begin w_status = STS_BAD_TOKEN; w_finish = 1'b1; end
              endcase
            end
          end else begin
            w_tok    = {r_tok[1:0], dat_in[0]};
            w_tokcnt = r_tokcnt + 2'd1;
          end
        end
      end
      DAT_BUSY: begin
        if (w_smp) begin
          if (dat_in[0]) begin
            w_status = STS_OK;
            w_finish = 1'b1;
          end else if (w_busy_inc >= {1'b0, r_busy_to}) begin
            w_status = STS_BUSY_TO;
            w_finish = 1'b1;
          end else begin
            w_busy_cnt = w_busy_inc;
          end
        end
      end
      default: w_state = DAT_IDLE;
    endcase

    // Every exit path releases the bus and drops any buffered byte in the same cycle.
    if (w_finish) begin
      w_state     = DAT_IDLE;
      w_done      = 1'b1;
      w_dat_en    = 1'b0;
      w_dat_out   = '1;
      w_hold_full = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= DAT_IDLE;
      r_dat_out   <= '1;
      r_dat_en    <= 1'b0;
      r_done      <= 1'b0;
      r_status    <= STS_OK;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_cur       <= '0;
      r_fetched   <= '0;
      r_nib       <= '0;
      r_bit       <= 4'd15;
      r_win       <= '0;
      r_tok       <= '0;
      r_tokcnt    <= '0;
      r_busy_to   <= '0;
      r_busy_cnt  <= '0;
    end else begin
      r_state     <= w_state;
      r_dat_out   <= w_dat_out;
      r_dat_en    <= w_dat_en;
      r_done      <= w_done;
      r_status    <= w_status;
      r_hold      <= w_hold;
      r_hold_full <= w_hold_full;
      r_cur       <= w_cur;
      r_fetched   <= w_fetched;
      r_nib       <= w_nib;
      r_bit       <= w_bit;
      r_win       <= w_win;
      r_tok       <= w_tok;
      r_tokcnt    <= w_tokcnt;
      r_busy_to   <= w_busy_to;
      r_busy_cnt  <= w_busy_cnt;
    end
  end

  assign dat_out = r_dat_out;
  assign dat_en  = r_dat_en;
  assign done    = r_done;
  assign status  = r_status;
  assign active  = (r_state != DAT_IDLE);

endmodule

// File: tb/tb_sdc_dat_tx.sv
// Directed bench for sdc_dat_tx: models the host byte source and the card (token, busy) side.
module tb_sdc_dat_tx;

  localparam int BB    = 512;
  localparam int TOTAL = 1 + 2 * BB + 16 + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] busy_timeout = '0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        clk_out_stb = 1'b0;
  logic        clk_sample_stb = 1'b0;
  logic [3:0]  dat_in = '1;
  logic [3:0]  dat_out;
  logic        dat_en;
  logic        active;
  logic        done;
  logic [2:0]  status;

  sdc_dat_tx #(.BLOCK_BYTES(BB), .TOKEN_WINDOW(16), .BUSY_TO_BITS(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .busy_timeout   (busy_timeout),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .clk_out_stb    (clk_out_stb),
    .clk_sample_stb (clk_sample_stb),
    .dat_in         (dat_in),
    .dat_out        (dat_out),
    .dat_en         (dat_en),
    .active         (active),
    .done           (done),
    .status         (status)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] tx [BB];
  logic [3:0] cap [$];
  bit         resp [$];
  int         n_avail = 0;
  int         idx = 0;
  bit         acc_pend = 0;
  bit         armed = 0;
  bit         prev_en = 0;
  int         samp_cnt = 0;
  int         done_cnt = 0;
  int         done_samp = 0;
  logic [2:0] done_status = '0;
  logic       done_active = 1'b0;
  int         phase = 0;

  // Strobe generator, byte source and card model; all inputs change on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (clk_out_stb) begin
        if (dat_en) cap.push_back(dat_out);
        if (prev_en && !dat_en) armed = 1;
        prev_en = dat_en;
      end
      if (done) begin
        done_cnt++;
        done_status = status;
        done_samp = samp_cnt;
        done_active = active;
      end
      if (acc_pend) idx++;
      phase = (phase + 1) % 4;
      clk_out_stb = (phase == 0);
      clk_sample_stb = (phase == 2);
      if (clk_sample_stb) begin
        if (armed) begin
          samp_cnt++;
          dat_in = {3'b111, (resp.size() > 0) ? resp.pop_front() : 1'b1};
        end else begin
          dat_in = '1;
        end
      end
      in_valid = (idx < n_avail);
      in_data = tx[(idx < BB) ? idx : 0];
      acc_pend = in_valid & in_ready;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_resp(input logic [4:0] tok, input int zeros);
    for (int i = 4; i >= 0; i--) resp.push_back(tok[i]);
    for (int i = 0; i < zeros; i++) resp.push_back(1'b0);
  endtask

  task automatic run_block(input int avail, input logic [15:0] bto);
    @(posedge clk); #1;
    cap.delete();
    armed = 0;
    prev_en = 0;
    samp_cnt = 0;
    done_cnt = 0;
    idx = 0;
    n_avail = avail;
    busy_timeout = bto;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 6000 && done_cnt == 0; i++) @(posedge clk);
    repeat (8) @(posedge clk);
    #1;
    chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
  endtask

  function automatic logic [15:0] gold_crc(input int line);
    logic [15:0] c;
    logic        b;
    logic        fb;
    c = 16'h0000;
    for (int k = 0; k < BB; k++) begin
      for (int h = 1; h >= 0; h--) begin
        b = tx[k][4 * h + line];
        fb = c[15] ^ b;
        c = c << 1;
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  function automatic logic [15:0] cap_crc(input int line);
    logic [15:0] c;
    logic [3:0]  n;
    c = 16'h0000;
    for (int j = 0; j < 16; j++) begin
      n = cap[1 + 2 * BB + j];
      c[15 - j] = n[line];
    end
    return c;
  endfunction

  task automatic check_data(input string tag);
    logic [15:0] g [4];
    logic [3:0]  e;
    logic [7:0]  byt;
    int          bad;
    for (int l = 0; l < 4; l++) g[l] = gold_crc(l);
    chk({tag, "_driven"}, 32'(cap.size()), 32'(TOTAL));
    if (cap.size() == TOTAL) begin
      bad = 0;
      for (int i = 0; i < TOTAL; i++) begin
        if (i == 0) e = 4'h0;
        else if (i <= 2 * BB) begin
          byt = tx[(i - 1) / 2];
          e = (i % 2 == 1) ? byt[7:4] : byt[3:0];
        end else if (i < TOTAL - 1) begin
          e = {g[3][15 - (i - 1 - 2 * BB)], g[2][15 - (i - 1 - 2 * BB)],
               g[1][15 - (i - 1 - 2 * BB)], g[0][15 - (i - 1 - 2 * BB)]};
        end else e = 4'hF;
        if (cap[i] !== e) bad++;
      end
      chk({tag, "_nibble_errs"}, 32'(bad), 32'd0);
      for (int l = 0; l < 4; l++) chk($sformatf("%s_crc%0d", tag, l), 32'(cap_crc(l)), 32'(g[l]));
    end
  endtask

  task automatic check_end(input string tag, input logic [2:0] st, input int samples);
    chk({tag, "_status"}, 32'(done_status), 32'(st));
    chk({tag, "_samples"}, 32'(done_samp), 32'(samples));
    chk({tag, "_dat_en"}, 32'(dat_en), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dat_en", 32'(dat_en), 32'd0);
    chk("rst_dat_out", 32'(dat_out), 32'hF);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    rst_n = 1'b1;

    // All-zero block: two idle samples, token 010, 20 busy samples, then ready.
    for (int i = 0; i < BB; i++) tx[i] = 8'h00;
    resp.delete();
    resp.push_back(1'b1); resp.push_back(1'b1);
    push_resp(5'b00101, 20);
    resp.push_back(1'b1);
    run_block(BB, 16'd1000);
    wait_done("zero");
    check_data("zero");
    for (int l = 0; l < 4; l++) chk($sformatf("zero_crc%0d_const", l), 32'(cap_crc(l)), 32'd0);
    check_end("zero", 3'd0, 28);
    chk("zero_active_at_done", 32'(done_active), 32'd0);

    // Random payload, card reports ready on the first busy sample.
    for (int i = 0; i < BB; i++) tx[i] = 8'($urandom);
    resp.delete();
    push_resp(5'b00101, 0);
    run_block(BB, 16'd1000);
    wait_done("rand");
    check_data("rand");
    check_end("rand", 3'd0, 6);

    resp.delete();
    push_resp(5'b01011, 0);
    run_block(BB, 16'd1000);
    wait_done("tok101");
    check_end("tok101", 3'd1, 5);

    resp.delete();
    push_resp(5'b01101, 0);
    run_block(BB, 16'd1000);
    wait_done("tok110");
    check_end("tok110", 3'd2, 5);

    resp.delete();
    push_resp(5'b00100, 0);
    run_block(BB, 16'd1000);
    wait_done("badend");
    check_end("badend", 3'd6, 5);

    resp.delete();
    run_block(BB, 16'd1000);
    wait_done("notoken");
    check_end("notoken", 3'd3, 16);

    resp.delete();
    push_resp(5'b00101, 200);
    run_block(BB, 16'd100);
    wait_done("busyto");
    check_end("busyto", 3'd4, 105);

    resp.delete();
    push_resp(5'b00101, 10);
    run_block(BB, 16'd0);
    wait_done("busyto0");
    check_end("busyto0", 3'd4, 6);

    // Source stops after 10 bytes: bus released at the 11th byte's high nibble.
    resp.delete();
    run_block(10, 16'd1000);
    wait_done("underrun");
    chk("underrun_status", 32'(done_status), 32'd5);
    chk("underrun_driven", 32'(cap.size()), 32'd21);
    chk("underrun_dat_en", 32'(dat_en), 32'd0);
    chk("underrun_dat_out", 32'(dat_out), 32'hF);

    // Reset in the middle of the payload, then a clean block.
    resp.delete();
    run_block(BB, 16'd1000);
    for (int i = 0; i < 4000 && cap.size() < 100; i++) @(posedge clk);
    chk("rstmid_reached_data", 32'(cap.size() >= 100), 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_dat_en", 32'(dat_en), 32'd0);
    chk("rstmid_dat_out", 32'(dat_out), 32'hF);
    chk("rstmid_active", 32'(active), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rstmid_no_done", 32'(done_cnt), 32'd0);
    for (int i = 0; i < BB; i++) tx[i] = 8'($urandom);
    resp.delete();
    push_resp(5'b00101, 3);
    run_block(BB, 16'd1000);
    wait_done("after_rst");
    check_data("after_rst");
    check_end("after_rst", 3'd0, 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
